// File: rtl/cpu_pkg.sv
// Shared definitions for the boot sequencer: FSM encoding, the memory-select
// address bit and default timing constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARM   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } boot_state_e;

    localparam int MEM_SEL_BIT      = 14;
    localparam int DEFAULT_DEBOUNCE = 20;
    localparam int DEFAULT_RST_HOLD = 16;
    localparam int DEFAULT_TIMEOUT  = 2**24;
    localparam int DEFAULT_CNT_W    = 16;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-high counter and a
// single-cycle press pulse that re-arms only after the button is released.
module btn_debounce #(
    parameter int DEBOUNCE = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic btn,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    logic            sync1_r;
    logic            sync2_r;
    logic [DB_W-1:0] cnt_r;
    logic [DB_W-1:0] cnt_next_s;
    logic            press_r;

    // Next debounce count; saturates at DEBOUNCE so the pulse value is hit once per press.
    always_comb begin
        cnt_next_s = cnt_r;
        if (!sync2_r) begin
            cnt_next_s = {DB_W{1'b0}};
        end else if (cnt_r != DB_W'(DEBOUNCE)) begin
            cnt_next_s = cnt_r + DB_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Synchronizer, counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= {DB_W{1'b0}};
            press_r <= 1'b0;
        end else if (srst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= {DB_W{1'b0}};
            press_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_next_s;
            press_r <= sync2_r && (cnt_next_s == DB_W'(DEBOUNCE - 1));
        end
    end

    assign press = press_r;

endmodule

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: switches the CPU between RUN and UART programming, owns the
// programmer/CPU resets and steers programmer writes to ROM or data memory.
import cpu_pkg::*;

module boot_seq_ctrl #(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int RST_HOLD = DEFAULT_RST_HOLD,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst_n,
    input  logic             start_pg,
    input  logic             upg_wen_i,
    input  logic [14:0]      upg_adr_i,
    input  logic [31:0]      upg_dat_i,
    input  logic             upg_done_i,
    output logic             upg_rst_o,
    output logic             cpu_rst_o,
    output logic             rom_wen_o,
    output logic             ram_wen_o,
    output logic [13:0]      mem_adr_o,
    output logic [31:0]      mem_dat_o,
    output logic [CNT_W-1:0] rom_words_o,
    output logic [CNT_W-1:0] ram_words_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    boot_state_e        state_r;
    logic               press_s;
    logic               timeout_s;
    logic               upg_rst_r;
    logic               cpu_rst_r;
    logic               busy_r;
    logic               err_r;
    logic               rom_wen_r;
    logic               ram_wen_r;
    logic [13:0]        mem_adr_r;
    logic [31:0]        mem_dat_r;
    logic [CNT_W-1:0]   rom_cnt_r;
    logic [CNT_W-1:0]   ram_cnt_r;
    logic [IDLE_W-1:0]  idle_r;
    logic [HOLD_W-1:0]  hold_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_start_db (
        .clk   (fpga_clk),
        .rst_n (fpga_rst_n),
        .srst  (1'b0),
        .btn   (start_pg),
        .press (press_s)
    );

    // A write in the same cycle restarts the idle window, so it cannot time out.
    always_comb begin
        if (upg_wen_i) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = (idle_r == IDLE_W'(TIMEOUT - 1));
        end
    end

    // Sequencer FSM; every output register is loaded with its next-state value.
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_r   <= ST_RUN;
            upg_rst_r <= 1'b1;
            cpu_rst_r <= 1'b1;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            rom_wen_r <= 1'b0;
            ram_wen_r <= 1'b0;
            mem_adr_r <= 14'd0;
            mem_dat_r <= 32'd0;
            rom_cnt_r <= {CNT_W{1'b0}};
            ram_cnt_r <= {CNT_W{1'b0}};
            idle_r    <= {IDLE_W{1'b0}};
            hold_r    <= {HOLD_W{1'b0}};
        end else begin
            rom_wen_r <= 1'b0;
            ram_wen_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    upg_rst_r <= 1'b1;
                    if (press_s) begin
                        state_r   <= ST_ARM;
                        cpu_rst_r <= 1'b1;
                        busy_r    <= 1'b1;
                        err_r     <= 1'b0;
                        rom_cnt_r <= {CNT_W{1'b0}};
                        ram_cnt_r <= {CNT_W{1'b0}};
                        idle_r    <= {IDLE_W{1'b0}};
                    end else begin
                        cpu_rst_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_ARM: begin
                    state_r   <= ST_LOAD;
                    upg_rst_r <= 1'b0;
                    cpu_rst_r <= 1'b1;
                    busy_r    <= 1'b1;
                    idle_r    <= {IDLE_W{1'b0}};
                end
                ST_LOAD: begin
                    if (upg_wen_i) begin
                        mem_adr_r <= upg_adr_i[13:0];
                        mem_dat_r <= upg_dat_i;
                        idle_r    <= {IDLE_W{1'b0}};
                        if (upg_adr_i[MEM_SEL_BIT]) begin
                            ram_wen_r <= 1'b1;
                            ram_cnt_r <= sat_inc(ram_cnt_r);
                        end else begin
                            rom_wen_r <= 1'b1;
                            rom_cnt_r <= sat_inc(rom_cnt_r);
                        end
                    end else begin
                        idle_r <= idle_r + IDLE_W'(1);
                    end
                    // Timeout outranks done: both go to FLUSH, only timeout flags an error.
                    if (timeout_s || upg_done_i) begin
                        state_r   <= ST_FLUSH;
                        upg_rst_r <= 1'b1;
                        hold_r    <= {HOLD_W{1'b0}};
                        err_r     <= err_r | timeout_s;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    upg_rst_r <= 1'b1;
                    if (hold_r == HOLD_W'(RST_HOLD - 1)) begin
                        state_r   <= ST_RUN;
                        cpu_rst_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_RUN;
                    upg_rst_r <= 1'b1;
                    cpu_rst_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign upg_rst_o   = upg_rst_r;
    assign cpu_rst_o   = cpu_rst_r;
    assign rom_wen_o   = rom_wen_r;
    assign ram_wen_o   = ram_wen_r;
    assign mem_adr_o   = mem_adr_r;
    assign mem_dat_o   = mem_dat_r;
    assign rom_words_o = rom_cnt_r;
    assign ram_words_o = ram_cnt_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl: reset, debounce, write steering, flush,
// timeout and reset during a load.
module tb_boot_seq_ctrl;

    logic        fpga_clk;
    logic        fpga_rst_n;
    logic        start_pg;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic [31:0] upg_dat_i;
    logic        upg_done_i;
    logic        upg_rst_o;
    logic        cpu_rst_o;
    logic        rom_wen_o;
    logic        ram_wen_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic [15:0] rom_words_o;
    logic [15:0] ram_words_o;
    logic        busy_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    logic both_seen = 1'b0;

    boot_seq_ctrl #(
        .DEBOUNCE (20),
        .RST_HOLD (16),
        .TIMEOUT  (100),
        .CNT_W    (16)
    ) dut (
        .fpga_clk    (fpga_clk),
        .fpga_rst_n  (fpga_rst_n),
        .start_pg    (start_pg),
        .upg_wen_i   (upg_wen_i),
        .upg_adr_i   (upg_adr_i),
        .upg_dat_i   (upg_dat_i),
        .upg_done_i  (upg_done_i),
        .upg_rst_o   (upg_rst_o),
        .cpu_rst_o   (cpu_rst_o),
        .rom_wen_o   (rom_wen_o),
        .ram_wen_o   (ram_wen_o),
        .mem_adr_o   (mem_adr_o),
        .mem_dat_o   (mem_dat_o),
        .rom_words_o (rom_words_o),
        .ram_words_o (ram_words_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    always @(negedge fpga_clk) begin
        if (rom_wen_o && ram_wen_o) both_seen = 1'b1;
    end

    task automatic test_reset;
        fpga_rst_n = 1'b0;
        repeat (3) @(negedge fpga_clk);
        total++;
        if (cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0 ||
            rom_wen_o !== 1'b0 || ram_wen_o !== 1'b0 || mem_adr_o !== 14'd0 || mem_dat_o !== 32'd0 ||
            rom_words_o !== 16'd0 || ram_words_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_values: cpu_rst=%b upg_rst=%b busy=%b err=%b wen=%b%b adr=%h dat=%h rom=%0d ram=%0d",
                     cpu_rst_o, upg_rst_o, busy_o, err_o, rom_wen_o, ram_wen_o, mem_adr_o, mem_dat_o,
                     rom_words_o, ram_words_o);
        end
        fpga_rst_n = 1'b1;
        #1;
        total++;
        if (cpu_rst_o !== 1'b1) begin
            bad++;
            $display("FAIL cpu_rst_after_release: got %b want 1", cpu_rst_o);
        end
        @(negedge fpga_clk);
        total++;
        if (cpu_rst_o !== 1'b0 || upg_rst_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL run_entry: cpu_rst=%b upg_rst=%b busy=%b want 0 1 0", cpu_rst_o, upg_rst_o, busy_o);
        end
    endtask

    task automatic test_short_press;
        logic seen = 1'b0;
        start_pg = 1'b1;
        repeat (5) @(negedge fpga_clk);
        start_pg = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge fpga_clk);
            if (busy_o !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL short_press: busy went high, want no transition");
        end
    endtask

    task automatic test_press;
        int n = 0;
        int rises = 0;
        logic prev_busy = 1'b0;
        start_pg = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge fpga_clk);
            if (busy_o === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = busy_o;
            if (n == 0 && upg_rst_o === 1'b0) n = i;
        end
        start_pg = 1'b0;
        repeat (10) begin
            @(negedge fpga_clk);
            if (busy_o === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = busy_o;
        end
        total++;
        if (n < 20 || n > 23) begin
            bad++;
            $display("FAIL press_latency: LOAD reached after %0d cycles, want 20..23", n);
        end
        total++;
        if (rises != 1 || busy_o !== 1'b1 || upg_rst_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
            bad++;
            $display("FAIL single_arm: rises=%0d busy=%b upg_rst=%b cpu_rst=%b want 1 1 0 1",
                     rises, busy_o, upg_rst_o, cpu_rst_o);
        end
    endtask

    task automatic test_writes;
        upg_wen_i = 1'b1;
        upg_adr_i = 15'h0003;
        upg_dat_i = 32'hDEADBEEF;
        @(negedge fpga_clk);
        total++;
        if (rom_wen_o !== 1'b1 || ram_wen_o !== 1'b0 || mem_adr_o !== 14'h0003 ||
            mem_dat_o !== 32'hDEADBEEF || rom_words_o !== 16'd1 || ram_words_o !== 16'd0) begin
            bad++;
            $display("FAIL rom_write: wen=%b%b adr=%h dat=%h rom=%0d ram=%0d want 10 0003 deadbeef 1 0",
                     rom_wen_o, ram_wen_o, mem_adr_o, mem_dat_o, rom_words_o, ram_words_o);
        end
        upg_adr_i = 15'h4010;
        upg_dat_i = 32'h12345678;
        @(negedge fpga_clk);
        total++;
        if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b1 || mem_adr_o !== 14'h0010 ||
            mem_dat_o !== 32'h12345678 || rom_words_o !== 16'd1 || ram_words_o !== 16'd1) begin
            bad++;
            $display("FAIL ram_write: wen=%b%b adr=%h dat=%h rom=%0d ram=%0d want 01 0010 12345678 1 1",
                     rom_wen_o, ram_wen_o, mem_adr_o, mem_dat_o, rom_words_o, ram_words_o);
        end
        upg_wen_i = 1'b0;
        @(negedge fpga_clk);
        total++;
        if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL write_idle: wen=%b%b busy=%b want 00 1", rom_wen_o, ram_wen_o, busy_o);
        end
    endtask

    task automatic test_done_flush;
        int k = 1;
        upg_wen_i  = 1'b1;
        upg_done_i = 1'b1;
        upg_adr_i  = 15'h0004;
        upg_dat_i  = 32'hCAFEF00D;
        @(negedge fpga_clk);
        upg_wen_i  = 1'b0;
        upg_done_i = 1'b0;
        total++;
        if (rom_wen_o !== 1'b1 || rom_words_o !== 16'd2 || mem_dat_o !== 32'hCAFEF00D ||
            upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
            bad++;
            $display("FAIL done_write: rom_wen=%b rom=%0d dat=%h upg_rst=%b cpu_rst=%b want 1 2 cafef00d 1 1",
                     rom_wen_o, rom_words_o, mem_dat_o, upg_rst_o, cpu_rst_o);
        end
        while (k < 40) begin
            @(negedge fpga_clk);
            if (cpu_rst_o !== 1'b1) break;
            k++;
        end
        total++;
        if (k != 16) begin
            bad++;
            $display("FAIL flush_hold: cpu_rst high %0d cycles, want 16", k);
        end
        total++;
        if (busy_o !== 1'b0 || upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b0 ||
            rom_words_o !== 16'd2 || ram_words_o !== 16'd1) begin
            bad++;
            $display("FAIL back_to_run: busy=%b upg_rst=%b cpu_rst=%b rom=%0d ram=%0d want 0 1 0 2 1",
                     busy_o, upg_rst_o, cpu_rst_o, rom_words_o, ram_words_o);
        end
    endtask

    task automatic test_wen_in_run;
        logic seen = 1'b0;
        upg_wen_i = 1'b1;
        upg_adr_i = 15'h0005;
        upg_dat_i = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge fpga_clk);
            if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b0) seen = 1'b1;
            upg_adr_i = 15'h4005;
        end
        upg_wen_i = 1'b0;
        @(negedge fpga_clk);
        total++;
        if (seen !== 1'b0 || rom_words_o !== 16'd2 || ram_words_o !== 16'd1) begin
            bad++;
            $display("FAIL wen_in_run: enable_seen=%b rom=%0d ram=%0d want 0 2 1", seen, rom_words_o, ram_words_o);
        end
    endtask

    task automatic test_timeout;
        int k = 0;
        int w = 0;
        start_pg = 1'b1;
        while (upg_rst_o !== 1'b0 && w < 40) begin
            @(negedge fpga_clk);
            w++;
        end
        start_pg = 1'b0;
        total++;
        if (upg_rst_o !== 1'b0 || rom_words_o !== 16'd0 || ram_words_o !== 16'd0) begin
            bad++;
            $display("FAIL load_entry2: upg_rst=%b rom=%0d ram=%0d want 0 0 0", upg_rst_o, rom_words_o, ram_words_o);
        end
        k = 1;
        while (k < 200) begin
            @(negedge fpga_clk);
            if (upg_rst_o !== 1'b0) break;
            k++;
        end
        total++;
        if (k != 100 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout: LOAD lasted %0d cycles err=%b, want 100 1", k, err_o);
        end
        w = 0;
        while (busy_o !== 1'b0 && w < 40) begin
            @(negedge fpga_clk);
            w++;
        end
        total++;
        if (busy_o !== 1'b0 || cpu_rst_o !== 1'b0 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_run: busy=%b cpu_rst=%b err=%b want 0 0 1", busy_o, cpu_rst_o, err_o);
        end
        repeat (3) @(negedge fpga_clk);
        start_pg = 1'b1;
        w = 0;
        while (busy_o !== 1'b1 && w < 40) begin
            @(negedge fpga_clk);
            w++;
        end
        total++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: busy=%b err=%b want 1 0", busy_o, err_o);
        end
        start_pg = 1'b0;
        w = 0;
        while (upg_rst_o !== 1'b0 && w < 10) begin
            @(negedge fpga_clk);
            w++;
        end
    endtask

    task automatic test_reset_mid_load;
        total++;
        if (upg_rst_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_load_setup: upg_rst=%b want 0", upg_rst_o);
        end
        upg_wen_i = 1'b1;
        upg_adr_i = 15'h0001;
        upg_dat_i = 32'hA5A5A5A5;
        #2;
        fpga_rst_n = 1'b0;
        #1;
        total++;
        if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b0 || cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 ||
            busy_o !== 1'b0 || mem_adr_o !== 14'd0 || mem_dat_o !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: wen=%b%b cpu_rst=%b upg_rst=%b busy=%b adr=%h dat=%h",
                     rom_wen_o, ram_wen_o, cpu_rst_o, upg_rst_o, busy_o, mem_adr_o, mem_dat_o);
        end
        @(negedge fpga_clk);
        total++;
        if (rom_wen_o !== 1'b0 || ram_wen_o !== 1'b0 || rom_words_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_no_pulse: wen=%b%b rom=%0d want 00 0", rom_wen_o, ram_wen_o, rom_words_o);
        end
        upg_wen_i  = 1'b0;
        fpga_rst_n = 1'b1;
        repeat (2) @(negedge fpga_clk);
        total++;
        if (rom_wen_o !== 1'b0 || busy_o !== 1'b0 || cpu_rst_o !== 1'b0 || upg_rst_o !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: rom_wen=%b busy=%b cpu_rst=%b upg_rst=%b want 0 0 0 1",
                     rom_wen_o, busy_o, cpu_rst_o, upg_rst_o);
        end
    endtask

    task automatic test_exclusive;
        total++;
        if (both_seen !== 1'b0) begin
            bad++;
            $display("FAIL wen_exclusive: rom_wen and ram_wen high together");
        end
    endtask

    initial begin
        fpga_rst_n = 1'b0;
        start_pg   = 1'b0;
        upg_wen_i  = 1'b0;
        upg_adr_i  = 15'd0;
        upg_dat_i  = 32'd0;
        upg_done_i = 1'b0;
        test_reset();
        test_short_press();
        test_press();
        test_writes();
        test_done_flush();
        test_wen_in_run();
        test_timeout();
        test_reset_mid_load();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
